// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: one WIDTH-bit ripple slice per clock, LSW first; result valid WORDS edges after accept, held in DONE until out_ready.
// Optional MP_ADD_SEQ_OVF_EN adds a signed-overflow output registered alongside cout.
module mp_add_seq #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] s,
  output logic                   cout,
`ifdef MP_ADD_SEQ_OVF_EN
  output logic                   ovf,
`endif
  output logic                   busy
);

  localparam int N  = WIDTH * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     a_reg, b_reg;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_sl, b_sl, sum;
  logic [WIDTH:0]   c;
  logic             last;
  logic             accept;

  assign last = (idx == IW'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared slice: select word idx of each operand and ripple through WIDTH full adders.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    sum  = '0;
    c    = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx == IW'(w)) begin
        a_sl = a_reg[w*WIDTH +: WIDTH];
        b_sl = b_reg[w*WIDTH +: WIDTH];
      end
    end
    c[0] = carry;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = a_sl[i] ^ b_sl[i] ^ c[i];
      c[i+1]   = (a_sl[i] & b_sl[i]) | (c[i] & (a_sl[i] ^ b_sl[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      cout  <= 1'b0;
`ifdef MP_ADD_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_reg <= a;
        b_reg <= sub ? ~b : b;
        carry <= sub | cin;
        idx   <= '0;
      end
      if (state == RUN) begin
        for (int w = 0; w < WORDS; w++) begin
          if (idx == IW'(w)) s[w*WIDTH +: WIDTH] <= sum;
        end
        carry <= c[WIDTH];
        idx   <= last ? '0 : idx + 1'b1;
        if (last) begin
          cout <= c[WIDTH];
`ifdef MP_ADD_SEQ_OVF_EN
          // Signed overflow: carry into the MSB disagrees with carry out of it.
          ovf  <= c[WIDTH] ^ c[WIDTH-1];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed and random checks of mp_add_seq (WIDTH=4, WORDS=4) against a wide-add reference.
module tb_mp_add_seq;
  localparam int WIDTH = 4;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, busy;
  logic [N-1:0] a, b, s;
`ifdef MP_ADD_SEQ_OVF_EN
  logic         ovf;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout),
`ifdef MP_ADD_SEQ_OVF_EN
    .ovf(ovf),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present an operand for one edge; the edge consumed here is the accept edge.
  task automatic start(input logic [N-1:0] av, input logic [N-1:0] bv, input logic ci, input logic sb);
    in_valid = 1'b1; a = av; b = bv; cin = ci; sub = sb;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                               input logic ci, input logic sb);
    logic [N:0]   r;
    logic [N-1:0] be;
    int           lat;
    be  = sb ? ~bv : bv;
    r   = {1'b0, av} + {1'b0, be} + {{N{1'b0}}, (sb | ci)};
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_s"}, 32'(s), 32'(r[N-1:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(r[N]));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
`ifdef MP_ADD_SEQ_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'((av[N-1] == be[N-1]) && (r[N-1] != av[N-1])));
`endif
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, "_rel_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rel_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic ci, input logic sb, input int stall);
    start(av, bv, ci, sb);
    expect_result(tag, av, bv, ci, sb);
    repeat (stall) tick;
    release_out(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick; tick;
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);

    // Directed vectors with hand-computed results.
    start(16'h1234, 16'h0FCD, 1'b0, 1'b0);
    expect_result("add_basic", 16'h1234, 16'h0FCD, 1'b0, 1'b0);
    chk("add_basic_s_hand", 32'(s), 32'h2201);
    chk("add_basic_cout_hand", 32'(cout), 32'd0);
    release_out("add_basic");

    start(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    expect_result("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("wrap_s_hand", 32'(s), 32'h0000);
    chk("wrap_cout_hand", 32'(cout), 32'd1);
    release_out("wrap");

    start(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    expect_result("sgn_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("sgn_ovf_s_hand", 32'(s), 32'h8000);
    release_out("sgn_ovf");

    start(16'h1234, 16'h0235, 1'b0, 1'b1);
    expect_result("sub", 16'h1234, 16'h0235, 1'b0, 1'b1);
    chk("sub_s_hand", 32'(s), 32'h0FFF);
    chk("sub_cout_hand", 32'(cout), 32'd1);
    release_out("sub");

    start(16'h0001, 16'h0002, 1'b1, 1'b1);
    expect_result("borrow", 16'h0001, 16'h0002, 1'b1, 1'b1);
    chk("borrow_s_hand", 32'(s), 32'hFFFF);
    chk("borrow_cout_hand", 32'(cout), 32'd0);
    release_out("borrow");

    // Ignored request during RUN/DONE, backpressure hold, then DONE with both in_valid and out_ready.
    start(16'h00AA, 16'h0055, 1'b1, 1'b0);
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("run_in_ready", 32'(in_ready), 32'd0);
      tick;
    end
    chk("hold_out_valid0", 32'(out_valid), 32'd1);
    chk("hold_s0", 32'(s), 32'h0100);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_s", 32'(s), 32'h0100);
      chk("hold_cout", 32'(cout), 32'd0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("both_in_ready", 32'(in_ready), 32'd1);
    chk("both_out_valid", 32'(out_valid), 32'd0);
    chk("both_busy", 32'(busy), 32'd0);
    tick;
    in_valid = 1'b0;
    expect_result("after_both", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    chk("after_both_s_hand", 32'(s), 32'hFFFE);
    release_out("after_both");

    // Reset two cycles after accept.
    start(16'h1111, 16'h2222, 1'b0, 1'b0);
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_s", 32'(s), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    do_op("post_rst", 16'h8001, 16'h8002, 1'b1, 1'b0, 0);

    // Random operands with random consumer stalls.
    for (int n = 0; n < 1000; n++) begin
      do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
